// File: rtl/pipeline_stage_regs_pkg.sv
// Shared definitions for the R/X/M/W datapath registers: bubble encoding,
// forwarding-vector bit positions and the forwarding source selector.
`ifndef NOP_INST
`define NOP_INST 16'h0000
`endif
`ifndef FWD_X1
`define FWD_X1 5
`define FWD_M1 4
`define FWD_W1 3
`define FWD_X2 2
`define FWD_M2 1
`define FWD_W2 0
`endif

package pipeline_stage_regs_pkg;

  localparam int FWD_W     = 6;
  localparam int FWD_SRC_W = 3;

  typedef enum logic [1:0] {
    SEL_X  = 2'd0,
    SEL_M  = 2'd1,
    SEL_W  = 2'd2,
    SEL_RD = 2'd3
  } fwd_sel_e;

  // Youngest producer wins: X over M over W, regfile only when nothing matches.
  function automatic fwd_sel_e fwd_pick(input logic [FWD_SRC_W-1:0] sel);
    if (sel[2])      return SEL_X;
    else if (sel[1]) return SEL_M;
    else if (sel[0]) return SEL_W;
    else             return SEL_RD;
  endfunction

endpackage

// File: rtl/pipeline_stage_regs_fwd_mux.sv
// Priority operand select for one source: {x,m,w} forwarding bits with
// regfile data as the fallback.
module pipeline_stage_regs_fwd_mux
  import pipeline_stage_regs_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [FWD_SRC_W-1:0] sel,
  input  logic [W-1:0]         res_x,
  input  logic [W-1:0]         res_m,
  input  logic [W-1:0]         res_w,
  input  logic [W-1:0]         rd,
  output logic [W-1:0]         y
);

  always_comb begin
    y = rd;
    case (fwd_pick(sel))
      SEL_X:   y = res_x;
      SEL_M:   y = res_m;
      SEL_W:   y = res_w;
      default: y = rd;
    endcase
  end

endmodule

// File: rtl/pipeline_stage_regs.sv
// R/X/M/W instruction and operand registers driven by the pipeline
// controller's enables, flush and forwarding vector.
module pipeline_stage_regs
  import pipeline_stage_regs_pkg::*;
#(
  parameter int             W        = 16,
  parameter logic [W-1:0]   NOP_INST = `NOP_INST,
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     inst_f,
  input  logic [W-1:0]     pc_f,
  input  logic             en_f,
  input  logic             en_r,
  input  logic             en_x,
  input  logic             en_m,
  input  logic             en_w,
  input  logic [FWD_W-1:0] forwarding,
  input  logic             flush,
  input  logic [W-1:0]     rd1,
  input  logic [W-1:0]     rd2,
  input  logic [W-1:0]     res_x,
  input  logic [W-1:0]     res_m,
  input  logic [W-1:0]     res_w,
  output logic [W-1:0]     inst_r,
  output logic [W-1:0]     inst_x,
  output logic [W-1:0]     inst_m,
  output logic [W-1:0]     inst_w,
  output logic [W-1:0]     pc_r,
  output logic [W-1:0]     pc_x,
  output logic [W-1:0]     opa_x,
  output logic [W-1:0]     opb_x,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [W-1:0]     inst_r_q, inst_r_d, inst_x_q, inst_x_d;
  logic [W-1:0]     inst_m_q, inst_m_d, inst_w_q, inst_w_d;
  logic [W-1:0]     pc_r_q, pc_r_d, pc_x_q, pc_x_d;
  logic [W-1:0]     opa_x_q, opa_x_d, opb_x_q, opb_x_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic [W-1:0]     opa_fwd, opb_fwd;
  logic             bub_r, bub_x, bub_m, bub_w;
  logic [2:0]       bub_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-2){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  pipeline_stage_regs_fwd_mux #(.W(W)) u_fwd_a (
    .sel   (forwarding[`FWD_X1:`FWD_W1]),
    .res_x (res_x),
    .res_m (res_m),
    .res_w (res_w),
    .rd    (rd1),
    .y     (opa_fwd)
  );

  pipeline_stage_regs_fwd_mux #(.W(W)) u_fwd_b (
    .sel   (forwarding[`FWD_X2:`FWD_W2]),
    .res_x (res_x),
    .res_m (res_m),
    .res_w (res_w),
    .rd    (rd2),
    .y     (opb_fwd)
  );

  always_comb begin
    inst_r_d = inst_r_q;
    inst_x_d = inst_x_q;
    inst_m_d = inst_m_q;
    inst_w_d = inst_w_q;
    pc_r_d   = pc_r_q;
    pc_x_d   = pc_x_q;
    opa_x_d  = opa_x_q;
    opb_x_d  = opb_x_q;
    bub_r    = 1'b0;
    bub_x    = 1'b0;
    bub_m    = 1'b0;
    bub_w    = 1'b0;

    // Flush overrides the enables for R and X; M/W are unaffected by it.
    if (flush) begin
      inst_r_d = NOP_INST;
      pc_r_d   = '0;
      inst_x_d = NOP_INST;
      pc_x_d   = '0;
      opa_x_d  = '0;
      opb_x_d  = '0;
      bub_r    = 1'b1;
      bub_x    = 1'b1;
    end else begin
      if (en_r) begin
        if (en_f) begin
          inst_r_d = inst_f;
          pc_r_d   = pc_f;
        end else begin
          inst_r_d = NOP_INST;
          pc_r_d   = '0;
          bub_r    = 1'b1;
        end
      end
      if (en_x) begin
        if (en_r) begin
          inst_x_d = inst_r_q;
          pc_x_d   = pc_r_q;
          opa_x_d  = opa_fwd;
          opb_x_d  = opb_fwd;
        end else begin
          inst_x_d = NOP_INST;
          pc_x_d   = '0;
          opa_x_d  = '0;
          opb_x_d  = '0;
          bub_x    = 1'b1;
        end
      end
    end

    if (en_m) begin
      inst_m_d = en_x ? inst_x_q : NOP_INST;
      bub_m    = !en_x;
    end
    if (en_w) begin
      inst_w_d = en_m ? inst_m_q : NOP_INST;
      bub_w    = !en_m;
    end

    bub_inc      = {2'b00, bub_r} + {2'b00, bub_x} + {2'b00, bub_m} + {2'b00, bub_w};
    bubble_cnt_d = sat_add(bubble_cnt_q, bub_inc);
    stall_cnt_d  = (!en_r && !flush) ? sat_add(stall_cnt_q, 3'd1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r_q     <= NOP_INST;
      inst_x_q     <= NOP_INST;
      inst_m_q     <= NOP_INST;
      inst_w_q     <= NOP_INST;
      pc_r_q       <= '0;
      pc_x_q       <= '0;
      opa_x_q      <= '0;
      opb_x_q      <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      inst_r_q     <= inst_r_d;
      inst_x_q     <= inst_x_d;
      inst_m_q     <= inst_m_d;
      inst_w_q     <= inst_w_d;
      pc_r_q       <= pc_r_d;
      pc_x_q       <= pc_x_d;
      opa_x_q      <= opa_x_d;
      opb_x_q      <= opb_x_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign inst_r     = inst_r_q;
  assign inst_x     = inst_x_q;
  assign inst_m     = inst_m_q;
  assign inst_w     = inst_w_q;
  assign pc_r       = pc_r_q;
  assign pc_x       = pc_x_q;
  assign opa_x      = opa_x_q;
  assign opb_x      = opb_x_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Scoreboard bench for pipeline_stage_regs: a stage-array reference model
// queues the expected state per edge, a monitor compares after each edge.
module tb_pipeline_stage_regs;

  localparam int          CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [15:0] NOP  = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   inst_f, pc_f, rd1, rd2, res_x, res_m, res_w;
  logic          en_f, en_r, en_x, en_m, en_w, flush;
  logic [5:0]    forwarding;
  logic [15:0]   inst_r, inst_x, inst_m, inst_w, pc_r, pc_x, opa_x, opb_x;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_stage_regs #(.W(16), .NOP_INST(16'h0000), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_f(inst_f), .pc_f(pc_f),
    .en_f(en_f), .en_r(en_r), .en_x(en_x), .en_m(en_m), .en_w(en_w),
    .forwarding(forwarding), .flush(flush), .rd1(rd1), .rd2(rd2),
    .res_x(res_x), .res_m(res_m), .res_w(res_w),
    .inst_r(inst_r), .inst_x(inst_x), .inst_m(inst_m), .inst_w(inst_w),
    .pc_r(pc_r), .pc_x(pc_x), .opa_x(opa_x), .opb_x(opb_x),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // One pipeline slot: instruction, PC and (for the X slot) its operands.
  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] b;
  } slot_t;

  typedef struct {
    logic [15:0] ir, ix, im, iw, pr, px, a, b;
    int          sc, bc;
  } exp_t;

  slot_t st[4];   // 0=R 1=X 2=M 3=W
  int    m_stall, m_bub;
  exp_t  sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic slot_t bubble();
    slot_t s;
    s.inst = NOP; s.pc = 16'h0; s.a = 16'h0; s.b = 16'h0;
    return s;
  endfunction

  // Operand for one source: youngest forwarded producer, else regfile data.
  function automatic logic [15:0] operand(input logic [2:0] xmw, input logic [15:0] rf);
    if (xmw[2]) return res_x;
    if (xmw[1]) return res_m;
    if (xmw[0]) return res_w;
    return rf;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) st[i] = bubble();
    m_stall = 0;
    m_bub   = 0;
  endtask

  task automatic m_step();
    slot_t old[4];
    slot_t fetch;
    bit    en[5];
    exp_t  e;
    en[0] = en_f; en[1] = en_r; en[2] = en_x; en[3] = en_m; en[4] = en_w;
    for (int i = 0; i < 4; i++) old[i] = st[i];
    fetch.inst = inst_f; fetch.pc = pc_f; fetch.a = 16'h0; fetch.b = 16'h0;
    for (int s = 0; s < 4; s++) begin
      if (flush && s < 2) begin
        st[s] = bubble();
        m_bub++;
      end else if (en[s+1]) begin
        if (en[s]) begin
          st[s] = (s == 0) ? fetch : old[s-1];
          if (s == 1) begin
            st[s].a = operand(forwarding[5:3], rd1);
            st[s].b = operand(forwarding[2:0], rd2);
          end
        end else begin
          st[s] = bubble();
          m_bub++;
        end
      end
    end
    if (!en_r && !flush) m_stall++;
    if (m_stall > CMAX) m_stall = CMAX;
    if (m_bub > CMAX) m_bub = CMAX;
    e.ir = st[0].inst; e.ix = st[1].inst; e.im = st[2].inst; e.iw = st[3].inst;
    e.pr = st[0].pc;   e.px = st[1].pc;   e.a  = st[1].a;    e.b  = st[1].b;
    e.sc = m_stall;    e.bc = m_bub;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected state per clock edge, compared just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("inst_r", inst_r, e.ir);
      chk("inst_x", inst_x, e.ix);
      chk("inst_m", inst_m, e.im);
      chk("inst_w", inst_w, e.iw);
      chk("pc_r", pc_r, e.pr);
      chk("pc_x", pc_x, e.px);
      chk("opa_x", opa_x, e.a);
      chk("opb_x", opb_x, e.b);
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
    end
  end

  task automatic set_en(input bit f, input bit r, input bit x, input bit m, input bit w);
    en_f = f; en_r = r; en_x = x; en_m = m; en_w = w;
  endtask

  task automatic go();
    m_step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_inst_r"}, inst_r, NOP);
    chk({tag, "_inst_x"}, inst_x, NOP);
    chk({tag, "_inst_m"}, inst_m, NOP);
    chk({tag, "_inst_w"}, inst_w, NOP);
    chk({tag, "_pc_r"}, pc_r, 16'h0);
    chk({tag, "_opa_x"}, opa_x, 16'h0);
    chk({tag, "_opb_x"}, opb_x, 16'h0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'h0);
    chk({tag, "_bubble"}, 32'(bubble_cnt), 32'h0);
  endtask

  task automatic randomize_data();
    inst_f = 16'($urandom); pc_f  = 16'($urandom);
    rd1    = 16'($urandom); rd2   = 16'($urandom);
    res_x  = 16'($urandom); res_m = 16'($urandom); res_w = 16'($urandom);
    forwarding = 6'($urandom);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      randomize_data();
      if ($urandom_range(0, 9) == 0) begin
        set_en(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        k = $urandom_range(0, 5);
        set_en(k < 1, k < 2, k < 3, k < 4, k < 5);
        set_en(!(k > 0), !(k > 1), !(k > 2), !(k > 3), !(k > 4));
      end
      flush = ($urandom_range(0, 7) == 0);
      go();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    inst_f = 16'h0; pc_f = 16'h0; rd1 = 16'h0; rd2 = 16'h0;
    res_x = 16'h0; res_m = 16'h0; res_w = 16'h0;
    forwarding = 6'h0; flush = 1'b0;
    set_en(1, 1, 1, 1, 1);
    m_reset();
    #1;
    chk_reset_state("por");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Straight flow: 1234 reaches R, X, M, W on successive edges.
    inst_f = 16'h1234; pc_f = 16'h0100;
    go();
    chk("flow_r", inst_r, 16'h1234);
    inst_f = 16'h5555; pc_f = 16'h0102;
    go();
    chk("flow_x", inst_x, 16'h1234);
    go();
    chk("flow_m", inst_m, 16'h1234);
    go();
    chk("flow_w", inst_w, 16'h1234);

    // Source 1: X and M both match, X is youngest.
    forwarding = 6'b110_000; res_x = 16'hAAAA; res_m = 16'hBBBB; rd1 = 16'h1111;
    go();
    chk("fwd_src1_x", opa_x, 16'hAAAA);

    // Source 2 from W.
    forwarding = 6'b000_001; res_w = 16'h0F0F; rd2 = 16'h0000;
    go();
    chk("fwd_src2_w", opb_x, 16'h0F0F);
    forwarding = 6'b000_000;

    // Stall R for three cycles: R holds, X fills with bubbles.
    set_en(0, 0, 1, 1, 1);
    repeat (3) go();
    chk("stall_hold_r", inst_r, 16'h5555);
    chk("stall_bubble_x", inst_x, NOP);
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    chk("stall_bub3", 32'(bubble_cnt), 32'd3);

    // Flush with 2222 in R and 3333 in X.
    set_en(1, 1, 1, 1, 1);
    inst_f = 16'h3333; go();
    inst_f = 16'h2222; go();
    chk("pre_flush_r", inst_r, 16'h2222);
    chk("pre_flush_x", inst_x, 16'h3333);
    flush = 1'b1; inst_f = 16'h4444;
    go();
    flush = 1'b0;
    chk("flush_r", inst_r, NOP);
    chk("flush_x", inst_x, NOP);
    chk("flush_m_adv", inst_m, 16'h3333);
    chk("flush_bub", 32'(bubble_cnt), 32'd5);

    random_cycles(400);

    // Asynchronous reset between edges.
    set_en(1, 1, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("async");
    m_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Long stall saturates both counters.
    set_en(0, 0, 1, 1, 1);
    repeat (CMAX + 40) begin
      randomize_data();
      go();
    end
    chk("sat_stall", 32'(stall_cnt), 32'(CMAX));
    chk("sat_bubble", 32'(bubble_cnt), 32'(CMAX));

    random_cycles(100);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
